// File: rtl/bram_arb_pkg.sv
// Shared widths, tag type and index helper for the dual-port BRAM round-robin arbiter.
package bram_arb_pkg;
    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned RAM_DEPTH_DEF = 1024;
    localparam int unsigned AW            = $clog2(RAM_DEPTH_DEF);
    localparam int unsigned IDW           = $clog2(NREQ_DEF);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    // Increment a requester index, wrapping at n (n need not be a power of two).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i, input int unsigned n);
        return (32'(i) + 32'd1 >= n) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/bram_tdp_rr_arbiter_rr_pick2.sv
// Combinational round-robin picker: first and second valid requesters scanning upward from ptr.
module rr_pick2
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            w0_val,
    output logic [PW-1:0]   w0_id,
    output logic            w1_val,
    output logic [PW-1:0]   w1_id
);
    always_comb begin
        int unsigned idx;
        idx    = 0;
        w0_val = 1'b0;
        w0_id  = '0;
        w1_val = 1'b0;
        w1_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (req[idx]) begin
                if (!w0_val) begin
                    w0_val = 1'b1;
                    w0_id  = PW'(idx);
                end else if (!w1_val) begin
                    w1_val = 1'b1;
                    w1_id  = PW'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/bram_tdp_rr_arbiter.sv
// Shares a true-dual-port write-first BRAM among NREQ requesters: two grants per cycle,
// same-address hazard serialisation, and fixed-latency read response routing.
module bram_tdp_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ       = NREQ_DEF,
    parameter int unsigned RAM_WIDTH  = 64,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req_val,
    input  logic [NREQ-1:0]                    req_we,
    input  logic [NREQ*$clog2(RAM_DEPTH)-1:0]  req_addr,
    input  logic [NREQ*RAM_WIDTH-1:0]          req_wdata,
    output logic [NREQ-1:0]                    req_rdy,
    output logic [NREQ-1:0]                    rsp_val,
    output logic [NREQ*RAM_WIDTH-1:0]          rsp_data,
    output logic                               bram_ena,
    output logic                               bram_enb,
    output logic                               bram_wea,
    output logic                               bram_web,
    output logic [$clog2(RAM_DEPTH)-1:0]       bram_addra,
    output logic [$clog2(RAM_DEPTH)-1:0]       bram_addrb,
    output logic [RAM_WIDTH-1:0]               bram_dina,
    output logic [RAM_WIDTH-1:0]               bram_dinb,
    output logic                               bram_regcea,
    output logic                               bram_regceb,
    output logic                               bram_rsta,
    output logic                               bram_rstb,
    input  logic [RAM_WIDTH-1:0]               bram_douta,
    input  logic [RAM_WIDTH-1:0]               bram_doutb
);
    localparam int unsigned ADDR_W = $clog2(RAM_DEPTH);

    logic [IDW-1:0]       rr_ptr;
    logic                 w0_val, w1_val;
    logic [IDW-1:0]       w0_id, w1_id;
    logic [ADDR_W-1:0]    addr_arr [NREQ];
    logic [RAM_WIDTH-1:0] wdata_arr [NREQ];
    logic [RAM_WIDTH-1:0] hold [NREQ];
    logic [ADDR_W-1:0]    addr0, addr1;
    logic                 we0, we1;
    logic                 grant_a, grant_b;
    tag_t                 pipe_a [RD_LATENCY];
    tag_t                 pipe_b [RD_LATENCY];
    tag_t                 done_a, done_b;

    rr_pick2 #(.NREQ(NREQ), .PW(IDW)) u_pick (
        .req    (req_val),
        .ptr    (rr_ptr),
        .w0_val (w0_val),
        .w0_id  (w0_id),
        .w1_val (w1_val),
        .w1_id  (w1_id)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
        end
    end

    always_comb begin
        addr0   = addr_arr[w0_id];
        addr1   = addr_arr[w1_id];
        we0     = req_we[w0_id];
        we1     = req_we[w1_id];
        grant_a = w0_val & ~rst;
        // Port B yields to port A whenever the pair touches one address and either writes.
        grant_b = w1_val & ~rst & ~((addr0 == addr1) & (we0 | we1));
        req_rdy = '0;
        if (grant_a) req_rdy[w0_id] = 1'b1;
        if (grant_b) req_rdy[w1_id] = 1'b1;
    end

    always_comb begin
        bram_ena    = grant_a;
        bram_wea    = grant_a & we0;
        bram_addra  = addr0;
        bram_dina   = wdata_arr[w0_id];
        bram_enb    = grant_b;
        bram_web    = grant_b & we1;
        bram_addrb  = addr1;
        bram_dinb   = wdata_arr[w1_id];
        bram_rsta   = rst;
        bram_rstb   = rst;
        bram_regcea = ~rst & ((RD_LATENCY == 1) | pipe_a[0].valid);
        bram_regceb = ~rst & ((RD_LATENCY == 1) | pipe_b[0].valid);
        done_a      = pipe_a[RD_LATENCY-1];
        done_b      = pipe_b[RD_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
            for (int unsigned i = 0; i < NREQ; i++) hold[i] <= '0;
        end else begin
            if (grant_a) rr_ptr <= wrap_inc(grant_b ? w1_id : w0_id, NREQ);
            pipe_a[0] <= '{valid: grant_a & ~we0, id: w0_id};
            pipe_b[0] <= '{valid: grant_b & ~we1, id: w1_id};
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (done_a.valid && done_a.id == IDW'(i)) hold[i] <= bram_douta;
                else if (done_b.valid && done_b.id == IDW'(i)) hold[i] <= bram_doutb;
            end
        end
    end

    // Completing reads bypass the hold register so data arrives in the same cycle as rsp_val.
    always_comb begin
        logic hit_a, hit_b;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        rsp_val  = '0;
        rsp_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            hit_a = done_a.valid & (done_a.id == IDW'(i));
            hit_b = done_b.valid & (done_b.id == IDW'(i));
            if (!rst) begin
                rsp_val[i] = hit_a | hit_b;
                rsp_data[i*RAM_WIDTH +: RAM_WIDTH] = hit_a ? bram_douta : hit_b ? bram_doutb : hold[i];
            end
        end
    end
endmodule

// File: tb/tb_bram_tdp_rr_arbiter.sv
// Bench for bram_tdp_rr_arbiter: behavioural BRAM, directed scenarios, then random traffic vs a queue model.
module tb_bram_tdp_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int D  = 1024;
    localparam int AW = 10;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_val, req_we, req_rdy, rsp_val;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata, rsp_data;
    logic            bram_ena, bram_enb, bram_wea, bram_web;
    logic [AW-1:0]   bram_addra, bram_addrb;
    logic [W-1:0]    bram_dina, bram_dinb, bram_douta, bram_doutb;
    logic            bram_regcea, bram_regceb, bram_rsta, bram_rstb;

    always #5 clk = ~clk;

    bram_tdp_rr_arbiter #(.NREQ(N), .RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rdy(req_rdy), .rsp_val(rsp_val), .rsp_data(rsp_data),
        .bram_ena(bram_ena), .bram_enb(bram_enb), .bram_wea(bram_wea), .bram_web(bram_web),
        .bram_addra(bram_addra), .bram_addrb(bram_addrb), .bram_dina(bram_dina), .bram_dinb(bram_dinb),
        .bram_regcea(bram_regcea), .bram_regceb(bram_regceb), .bram_rsta(bram_rsta), .bram_rstb(bram_rstb),
        .bram_douta(bram_douta), .bram_doutb(bram_doutb)
    );

    // Write-first true-dual-port BRAM with an output register (two-cycle read latency).
    logic [W-1:0] mem [D];
    logic [W-1:0] lat_a, lat_b, oreg_a, oreg_b;
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) begin mem[bram_addra] <= bram_dina; lat_a <= bram_dina; end
            else lat_a <= mem[bram_addra];
        end
        if (bram_enb) begin
            if (bram_web) begin mem[bram_addrb] <= bram_dinb; lat_b <= bram_dinb; end
            else lat_b <= mem[bram_addrb];
        end
        if (bram_rsta) oreg_a <= '0; else if (bram_regcea) oreg_a <= lat_a;
        if (bram_rstb) oreg_b <= '0; else if (bram_regceb) oreg_b <= lat_b;
    end
    assign bram_douta = oreg_a;
    assign bram_doutb = oreg_b;

    typedef struct { int id; int due; logic [W-1:0] data; } pend_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ptr = 0;
    pend_t pq[$];
    logic [W-1:0]  refmem [D];
    logic [W-1:0]  exp_hold [N];
    logic          cur_val [N];
    logic          cur_we [N];
    logic [AW-1:0] cur_addr [N];
    logic [W-1:0]  cur_data [N];
    int            wait_cnt [N];
    logic          prev_rd_a, prev_rd_b;
    logic [N-1:0]  last_rdy;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic do_rst);
        logic [N-1:0] exp_val, exp_rdy;
        int order[$];
        int w0, w1;
        bit ga, gb;
        @(negedge clk);
        rst = do_rst;
        for (int i = 0; i < N; i++) begin
            req_val[i] = cur_val[i];
            req_we[i]  = cur_we[i];
            req_addr[i*AW +: AW] = cur_addr[i];
            req_wdata[i*W +: W]  = cur_data[i];
        end
        #1;
        last_rdy = req_rdy;
        if (do_rst) begin
            check_eq("rst_rdy", W'(req_rdy), '0);
            check_eq("rst_en", W'({bram_ena, bram_enb, bram_regcea, bram_regceb}), '0);
            check_eq("rst_rsp_val", W'(rsp_val), '0);
            check_eq("rst_bram_rst", W'({bram_rsta, bram_rstb}), W'(2'b11));
            pq = {};
            ptr = 0;
            prev_rd_a = 1'b0;
            prev_rd_b = 1'b0;
            for (int i = 0; i < N; i++) begin exp_hold[i] = '0; wait_cnt[i] = 0; end
        end else begin
            exp_val = '0;
            for (int k = pq.size() - 1; k >= 0; k--) begin
                if (pq[k].due == cyc) begin
                    exp_val[pq[k].id] = 1'b1;
                    exp_hold[pq[k].id] = pq[k].data;
                    pq.delete(k);
                end
            end
            check_eq("rsp_val", W'(rsp_val), W'(exp_val));
            for (int i = 0; i < N; i++) check_eq($sformatf("rsp_data%0d", i), rsp_data[i*W +: W], exp_hold[i]);
            check_eq("regce", W'({bram_regcea, bram_regceb}), W'({prev_rd_a, prev_rd_b}));

            order = {};
            for (int k = 0; k < N; k++) if (cur_val[(ptr + k) % N]) order.push_back((ptr + k) % N);
            ga = order.size() > 0;
            gb = order.size() > 1;
            w0 = ga ? order[0] : 0;
            w1 = gb ? order[1] : 0;
            if (gb && cur_addr[w0] == cur_addr[w1] && (cur_we[w0] || cur_we[w1])) gb = 0;
            exp_rdy = '0;
            if (ga) exp_rdy[w0] = 1'b1;
            if (gb) exp_rdy[w1] = 1'b1;
            check_eq("req_rdy", W'(req_rdy), W'(exp_rdy));
            check_eq("en", W'({bram_ena, bram_enb}), W'({ga, gb}));
            check_eq("we", W'({bram_wea, bram_web}), W'({ga && cur_we[w0], gb && cur_we[w1]}));
            if (ga) begin
                check_eq("addra", W'(bram_addra), W'(cur_addr[w0]));
                if (cur_we[w0]) check_eq("dina", bram_dina, cur_data[w0]);
            end
            if (gb) begin
                check_eq("addrb", W'(bram_addrb), W'(cur_addr[w1]));
                if (cur_we[w1]) check_eq("dinb", bram_dinb, cur_data[w1]);
            end

            for (int i = 0; i < N; i++) if (cur_val[i]) wait_cnt[i]++;
            prev_rd_a = ga && !cur_we[w0];
            prev_rd_b = gb && !cur_we[w1];
            for (int g = 0; g < 2; g++) begin
                int id;
                if (g == 0 ? !ga : !gb) continue;
                id = (g == 0) ? w0 : w1;
                if (cur_we[id]) refmem[cur_addr[id]] = cur_data[id];
                else pq.push_back('{id: id, due: cyc + LAT, data: refmem[cur_addr[id]]});
                check_eq("starve", W'(wait_cnt[id] <= N), W'(1));
                wait_cnt[id] = 0;
                cur_val[id] = 1'b0;
            end
            if (ga) ptr = ((gb ? w1 : w0) + 1) % N;
        end
        cyc++;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        cur_val[i] = 1'b1; cur_we[i] = we; cur_addr[i] = a; cur_data[i] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) cur_val[i] = 1'b0;
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_val = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < D; i++) refmem[i] = '0;
        for (int i = 0; i < N; i++) begin
            cur_val[i] = 0; cur_we[i] = 0; cur_addr[i] = '0; cur_data[i] = '0;
        end
        step(1'b1); step(1'b1);
        idle(5);

        // Write then read-after-write of the same address on the next cycle.
        set_req(0, 1'b1, 10'h10, 64'hA5); step(1'b0);
        set_req(1, 1'b0, 10'h10, '0);     step(1'b0);
        idle(4);
        check_eq("raw_data", rsp_data[1*W +: W], 64'hA5);

        // Four continuous readers from rr_ptr=0 alternate pairs.
        step(1'b1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
            step(1'b0);
            check_eq($sformatf("rr_pair%0d", k), W'(last_rdy), (k == 1) ? W'(4'b1100) : W'(4'b0011));
        end
        idle(4);

        // Write/read hazard with rr_ptr=2: read deferred one cycle, sees new data.
        set_req(2, 1'b1, 10'h20, 64'h1234_5678_9ABC_DEF0);
        set_req(3, 1'b0, 10'h20, '0);
        step(1'b0);
        check_eq("hazard_g0", W'(last_rdy), W'(4'b0100));
        step(1'b0);
        check_eq("hazard_g1", W'(last_rdy), W'(4'b1000));
        idle(4);
        check_eq("hazard_data", rsp_data[3*W +: W], 64'h1234_5678_9ABC_DEF0);

        // Two reads to one address are both granted.
        set_req(0, 1'b0, 10'h20, '0);
        set_req(1, 1'b0, 10'h20, '0);
        step(1'b0);
        check_eq("dual_read", W'(last_rdy), W'(4'b0011));
        idle(4);

        // Reset one cycle after a read grant drops that read.
        set_req(2, 1'b0, 10'h20, '0); step(1'b0);
        step(1'b1);
        idle(4);
        set_req(1, 1'b0, 10'h10, '0); set_req(3, 1'b0, 10'h20, '0);
        step(1'b0);
        check_eq("post_rst_rdy", W'(last_rdy), W'(4'b1010));
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!cur_val[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom, $urandom});
            step(1'b0);
        end
        idle(6);
        check_eq("drain", W'(pq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
